// File: rtl/rc4_prga_decrypt_if.sv
// Controller handshake and the S / encrypted / decrypted memory ports of the RC4 PRGA stage.
// key_ok exists only when RC4_TEXT_CHECK_EN is defined.
interface rc4_prga_decrypt_if #(parameter int MSG_LEN = 32);
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  logic          start;
  logic          finish;
  logic [7:0]    s_addr;
  logic [7:0]    s_data;
  logic          s_wren;
  logic [7:0]    s_q;
  logic [AW-1:0] e_addr;
  logic [7:0]    e_q;
  logic [AW-1:0] d_addr;
  logic [7:0]    d_data;
  logic          d_wren;
`ifdef RC4_TEXT_CHECK_EN
  logic          key_ok;

  modport master (output start, s_q, e_q,
                  input  finish, s_addr, s_data, s_wren, e_addr, d_addr, d_data, d_wren, key_ok);
  modport slave  (input  start, s_q, e_q,
                  output finish, s_addr, s_data, s_wren, e_addr, d_addr, d_data, d_wren, key_ok);
`else
  modport master (output start, s_q, e_q,
                  input  finish, s_addr, s_data, s_wren, e_addr, d_addr, d_data, d_wren);
  modport slave  (input  start, s_q, e_q,
                  output finish, s_addr, s_data, s_wren, e_addr, d_addr, d_data, d_wren);
`endif
endinterface

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generation over a pre-shuffled S RAM, XOR-decrypting MSG_LEN ROM bytes into a RAM.
// Optional RC4_TEXT_CHECK_EN adds key_ok and aborts on the first byte that is not lowercase/space.
module rc4_prga_decrypt #(
  parameter int MSG_LEN = 32
) (
  input logic               clk,
  input logic               rst,
  rc4_prga_decrypt_if.slave bus
);
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [AW-1:0] K_LAST = AW'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH_SI, ST_CALC_J, ST_FETCH_SJ, ST_SWAP_I,
    ST_SWAP_J, ST_FETCH_F, ST_XOR, ST_WRITE_D, ST_DONE
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    i, j, si, sj, i_nx, j_nx, si_nx, sj_nx;
  logic [AW-1:0] k, k_nx;
  logic [7:0]    s_addr_r, s_addr_nx;
  logic          s_wren_r, s_wren_nx;
  logic [AW-1:0] e_addr_r, e_addr_nx, d_addr_r, d_addr_nx;
  logic [7:0]    d_data_r, d_data_nx;
  logic          d_wren_r, d_wren_nx;
  logic          finish_r, finish_nx;
  logic [7:0]    pt;
  logic          pt_ok;
`ifdef RC4_TEXT_CHECK_EN
  logic          key_ok_r, key_ok_nx;
`endif

  assign pt = bus.s_q ^ bus.e_q;
`ifdef RC4_TEXT_CHECK_EN
  assign pt_ok = ((pt >= 8'h61) && (pt <= 8'h7A)) || (pt == 8'h20);
`else
  assign pt_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      i        <= '0;
      j        <= '0;
      si       <= '0;
      sj       <= '0;
      k        <= '0;
      s_addr_r <= '0;
      s_wren_r <= 1'b0;
      e_addr_r <= '0;
      d_addr_r <= '0;
      d_data_r <= '0;
      d_wren_r <= 1'b0;
      finish_r <= 1'b0;
`ifdef RC4_TEXT_CHECK_EN
      key_ok_r <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      i        <= i_nx;
      j        <= j_nx;
      si       <= si_nx;
      sj       <= sj_nx;
      k        <= k_nx;
      s_addr_r <= s_addr_nx;
      s_wren_r <= s_wren_nx;
      e_addr_r <= e_addr_nx;
      d_addr_r <= d_addr_nx;
      d_data_r <= d_data_nx;
      d_wren_r <= d_wren_nx;
      finish_r <= finish_nx;
`ifdef RC4_TEXT_CHECK_EN
      key_ok_r <= key_ok_nx;
`endif
    end
  end

  // Each branch computes the output values the next state holds for its whole duration.
  always_comb begin
    state_nx  = state;
    i_nx      = i;
    j_nx      = j;
    si_nx     = si;
    sj_nx     = sj;
    k_nx      = k;
    s_addr_nx = s_addr_r;
    s_wren_nx = s_wren_r;
    e_addr_nx = e_addr_r;
    d_addr_nx = d_addr_r;
    d_data_nx = d_data_r;
    d_wren_nx = d_wren_r;
    finish_nx = finish_r;
`ifdef RC4_TEXT_CHECK_EN
    key_ok_nx = key_ok_r;
`endif
    case (state)
      ST_IDLE: if (bus.start) begin
        state_nx  = ST_FETCH_SI;
        i_nx      = 8'd1;
        j_nx      = '0;
        si_nx     = '0;
        sj_nx     = '0;
        k_nx      = '0;
        s_addr_nx = 8'd1;
`ifdef RC4_TEXT_CHECK_EN
        key_ok_nx = 1'b1;
`endif
      end
      ST_FETCH_SI: state_nx = ST_CALC_J;
      ST_CALC_J: begin
        si_nx     = bus.s_q;
        j_nx      = j + bus.s_q;
        s_addr_nx = j + bus.s_q;
        state_nx  = ST_FETCH_SJ;
      end
      // The read of S[j] is captured at this edge, so the address can move on to i.
      ST_FETCH_SJ: begin
        s_addr_nx = i;
        s_wren_nx = 1'b1;
        state_nx  = ST_SWAP_I;
      end
      ST_SWAP_I: begin
        sj_nx     = bus.s_q;
        s_addr_nx = j;
        state_nx  = ST_SWAP_J;
      end
      ST_SWAP_J: begin
        s_wren_nx = 1'b0;
        s_addr_nx = si + sj;
        e_addr_nx = k;
        state_nx  = ST_FETCH_F;
      end
      ST_FETCH_F: state_nx = ST_XOR;
      ST_XOR: begin
        if (pt_ok) begin
          d_data_nx = pt;
          d_addr_nx = k;
          d_wren_nx = 1'b1;
          state_nx  = ST_WRITE_D;
        end else begin
          finish_nx = 1'b1;
          state_nx  = ST_DONE;
`ifdef RC4_TEXT_CHECK_EN
          key_ok_nx = 1'b0;
`endif
        end
      end
      ST_WRITE_D: begin
        d_wren_nx = 1'b0;
        if (k == K_LAST) begin
          finish_nx = 1'b1;
          state_nx  = ST_DONE;
        end else begin
          k_nx      = k + 1'b1;
          i_nx      = i + 8'd1;
          s_addr_nx = i + 8'd1;
          state_nx  = ST_FETCH_SI;
        end
      end
      ST_DONE: state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // S[j] only arrives in SWAP_I, so that write forwards the read port; SWAP_J writes the saved S[i].
  assign bus.s_data = (state == ST_SWAP_I) ? bus.s_q : si;
  assign bus.s_addr = s_addr_r;
  assign bus.s_wren = s_wren_r;
  assign bus.e_addr = e_addr_r;
  assign bus.d_addr = d_addr_r;
  assign bus.d_data = d_data_r;
  assign bus.d_wren = d_wren_r;
  assign bus.finish = finish_r;
`ifdef RC4_TEXT_CHECK_EN
  assign bus.key_ok = key_ok_r;
`endif
endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Random and directed bench for rc4_prga_decrypt: behavioural RC4 model, RAM/ROM models, per-cycle write checker.
module tb_rc4_prga_decrypt;
  localparam int M = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  always #5 clk = ~clk;

  rc4_prga_decrypt_if #(.MSG_LEN(M)) bus();
  rc4_prga_decrypt #(.MSG_LEN(M)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] smem [256];
  logic [7:0] s_init [256];
  logic [7:0] enc [16];
  logic [7:0] dmem [16];

  always @(posedge clk) begin
    bus.s_q <= smem[bus.s_addr];
    bus.e_q <= enc[bus.e_addr];
    if (load) begin
      for (int a = 0; a < 256; a++) smem[a] <= s_init[a];
      for (int a = 0; a < 16; a++) dmem[a] <= 8'h00;
    end else begin
      if (bus.s_wren) smem[bus.s_addr] <= bus.s_data;
      if (bus.d_wren) dmem[bus.d_addr] <= bus.d_data;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---- behavioural RC4 model ----
  int ms [256];
  int ks [$];
  int exp_sw [$];
  int exp_d [$];
  int exp_pt [16];
  int exp_fs [256];
  int exp_nd, exp_lat;
  bit exp_ok;

  function automatic void prga(input int n);
    int i = 0, j = 0, t;
    ks.delete();
    exp_sw.delete();
    for (int b = 0; b < n; b++) begin
      i = (i + 1) % 256;
      j = (j + ms[i]) % 256;
      exp_sw.push_back(i * 256 + ms[j]);
      exp_sw.push_back(j * 256 + ms[i]);
      t = ms[i]; ms[i] = ms[j]; ms[j] = t;
      ks.push_back(ms[(ms[i] + ms[j]) % 256]);
    end
  endfunction

  function automatic void plan();
    int fail_at = -1;
    int p;
    for (int a = 0; a < 256; a++) ms[a] = int'(s_init[a]);
    prga(M);
    exp_d.delete();
    exp_nd = 0;
    for (int b = 0; b < M; b++) begin
      p = ks[b] ^ int'(enc[b]);
`ifdef RC4_TEXT_CHECK_EN
      if (!(((p >= 8'h61) && (p <= 8'h7A)) || p == 8'h20)) begin
        fail_at = b;
        break;
      end
`endif
      exp_d.push_back(b * 256 + p);
      exp_pt[b] = p;
      exp_nd++;
    end
    if (fail_at >= 0) begin
      for (int a = 0; a < 256; a++) ms[a] = int'(s_init[a]);
      prga(fail_at + 1);
      exp_lat = 8 * fail_at + 8;
      exp_ok  = 1'b0;
    end else begin
      exp_lat = 8 * M + 1;
      exp_ok  = 1'b1;
    end
    for (int a = 0; a < 256; a++) exp_fs[a] = ms[a];
  endfunction

  // ---- per-cycle write checker ----
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    int want;
    if (mon_en) begin
      chk("wren_excl", int'(bus.s_wren & bus.d_wren), 0);
      if (bus.s_wren) begin
        want = (exp_sw.size() > 0) ? exp_sw.pop_front() : -1;
        chk("s_write", int'({bus.s_addr, bus.s_data}), want);
      end
      if (bus.d_wren) begin
        want = (exp_d.size() > 0) ? exp_d.pop_front() : -1;
        chk("d_write", int'(bus.d_addr) * 256 + int'(bus.d_data), want);
      end
    end
  end

  // ---- stimulus helpers ----
  task automatic check_zero(input string name);
    chk({name, "_ctl"}, int'({bus.finish, bus.s_wren, bus.d_wren, bus.s_addr, bus.s_data}), 0);
    chk({name, "_addr"}, int'({bus.e_addr, bus.d_addr, bus.d_data}), 0);
`ifdef RC4_TEXT_CHECK_EN
    chk({name, "_keyok"}, int'(bus.key_ok), 0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic load_mem();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic rand_perm();
    int b;
    logic [7:0] t;
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    for (int a = 255; a > 0; a--) begin
      b = int'($urandom_range(a, 0));
      t = s_init[a]; s_init[a] = s_init[b]; s_init[b] = t;
    end
  endtask

  // enc chosen so the plaintext is random lowercase/space text
  task automatic text_enc();
    logic [7:0] c;
    for (int a = 0; a < 256; a++) ms[a] = int'(s_init[a]);
    prga(M);
    for (int b = 0; b < M; b++) begin
      c = ($urandom_range(26, 0) == 26) ? 8'h20 : 8'(8'h61 + $urandom_range(25, 0));
      enc[b] = 8'(ks[b]) ^ c;
    end
  endtask

  task automatic go(input string name, input bit hold);
    int n, nm;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); if (!hold) bus.start = 1'b0;
    n = 1;
    while (!bus.finish && n < 8 * M + 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_lat"}, n, exp_lat);
    if (hold) begin
      repeat (20) @(negedge clk);
      chk({name, "_fin_held"}, int'(bus.finish), 1);
      bus.start = 1'b0;
    end
    @(negedge clk);
    chk({name, "_sw_left"}, exp_sw.size(), 0);
    chk({name, "_d_left"}, exp_d.size(), 0);
    nm = 0;
    for (int a = 0; a < 256; a++) if (int'(smem[a]) != exp_fs[a]) nm++;
    chk({name, "_S_final"}, nm, 0);
    nm = 0;
    for (int b = 0; b < exp_nd; b++) if (int'(dmem[b]) != exp_pt[b]) nm++;
    chk({name, "_dmem"}, nm, 0);
`ifdef RC4_TEXT_CHECK_EN
    chk({name, "_keyok"}, int'(bus.key_ok), int'(exp_ok));
`endif
  endtask

  int ev [9];
  int ptxt [9];
  int key [3];
  int s_after4 [256];

  initial begin
    int kj, nw, cyc;
    logic [7:0] t;
    bus.start = 1'b0;
    ev   = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    ptxt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    key  = '{8'h4B, 8'h65, 8'h79};

    // identity S, zero ROM
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    for (int b = 0; b < 16; b++) enc[b] = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");
    for (int a = 0; a < 256; a++) ms[a] = a;
    prga(M);
    chk("model_ks0", ks[0], 8'h02);
    chk("model_ks1", ks[1], 8'h05);
    mon_en = 1'b1;
    load_mem();
    plan();
    go("ident", 1'b0);

    // KSA for key "Key", known ciphertext
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    kj = 0;
    for (int a = 0; a < 256; a++) begin
      kj = (kj + int'(s_init[a]) + key[a % 3]) % 256;
      t = s_init[a]; s_init[a] = s_init[kj]; s_init[kj] = t;
    end
    for (int b = 0; b < M; b++) enc[b] = 8'(ev[b]);
    for (int a = 0; a < 256; a++) ms[a] = int'(s_init[a]);
    prga(M);
    for (int b = 0; b < M; b++) chk("model_plaintext", ks[b] ^ ev[b], ptxt[b]);
    do_reset();
    check_zero("vec_rst");
    load_mem();
    plan();
    go("vec", 1'b0);

    // random S permutations with random ROM contents
    for (int r = 0; r < 4; r++) begin
      rand_perm();
      for (int b = 0; b < M; b++) enc[b] = 8'($urandom_range(255, 0));
      do_reset();
      load_mem();
      plan();
      go("rand", 1'b0);
    end

    // random S with a ROM that decrypts to text
    rand_perm();
    text_enc();
    do_reset();
    load_mem();
    plan();
    go("text", 1'b0);

    // reset during the second swap write of byte 3, then restart on the partly swapped S
    rand_perm();
    text_enc();
    do_reset();
    load_mem();
    for (int a = 0; a < 256; a++) ms[a] = int'(s_init[a]);
    prga(4);
    for (int a = 0; a < 256; a++) s_after4[a] = ms[a];
    plan();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    nw = 0;
    cyc = 0;
    while (nw < 8 && cyc < 200) begin
      if (bus.s_wren) nw++;
      if (nw < 8) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("mid_swapj_seen", nw, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("mid_rst");
    for (int a = 0; a < 256; a++) s_init[a] = 8'(s_after4[a]);
    plan();
    go("restart", 1'b0);

    // start held high all the way through DONE
    rand_perm();
    text_enc();
    do_reset();
    load_mem();
    plan();
    go("hold", 1'b1);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rc4_prga_decrypt.md
# rc4_prga_decrypt

RC4 pseudo-random generation and decrypt stage. It runs after the key-scheduling shuffle has left a permuted S array in the shared 256x8 working RAM. It generates `MSG_LEN` keystream bytes, swapping S entries as it goes. Each keystream byte is XORed with the matching byte of the encrypted-message ROM and written to the decrypted-message RAM. It is sequenced by the top-level controller through a start/finish handshake, the same way as the shuffle stage.

## Interface
- `MSG_LEN`, 32, message length in bytes (1..256); sizes ROM/RAM addressing.
- `clk`  in  1  clock.
- `rst`  in  1  reset rst, synchronous, active-high.
- `start`  in  1  sampled only in IDLE; high at a clk edge launches decryption.
- `finish`  out  1  high in DONE; held until `rst`.
- `s_addr`  out  8  S RAM address.
- `s_data`  out  8  S RAM write data.
- `s_wren`  out  1  S RAM write enable.
- `s_q`  in  8  S RAM read data.
- `e_addr`  out  $clog2(MSG_LEN)  encrypted ROM address.
- `e_q`  in  8  encrypted ROM data.
- `d_addr`  out  $clog2(MSG_LEN)  decrypted RAM address.
- `d_data`  out  8  decrypted RAM write data.
- `d_wren`  out  1  decrypted RAM write enable.
- `key_ok`  out  1  present only with `RC4_TEXT_CHECK_EN` (see Configuration).

## Operation
- Internal registers: `i`, `j`, `si`, `sj` (8 b each) and `k` (byte index). All are cleared on `rst` and on leaving IDLE.
- All outputs are registered. Each value below is set on entry to its state and held for the whole state.
- IDLE: all outputs 0. When `start` is high: `i`←1, `s_addr`←1, go to FETCH_SI.
- FETCH_SI: `s_addr`=i. Go to CALC_J.
- CALC_J: `s_q`=S[i]. Set `si`←`s_q` and `j`←`j`+`s_q` (mod 256). Drive `s_addr`←new j. Go to FETCH_SJ.
- FETCH_SJ: `s_addr`=j. Go to SWAP_I.
- SWAP_I: `s_q`=S[j]. Set `sj`←`s_q` and write `s_q` to address i (`s_wren`=1). Go to SWAP_J.
- SWAP_J: write `si` to address j (`s_wren`=1). Go to FETCH_F.
- FETCH_F: `s_wren`=0, `s_addr`=`si`+`sj` (mod 256), `e_addr`=k. Go to XOR.
- XOR: `s_q`=keystream byte and `e_q`=enc[k]. Register `d_data`←`s_q`^`e_q` and `d_addr`←k. Go to WRITE_D.
- WRITE_D: `d_wren`=1.
  - If k==MSG_LEN-1, go to DONE.
  - Otherwise k←k+1, i←i+1 (mod 256), `s_addr`←new i, go to FETCH_SI.
- DONE: `finish`=1 and all write enables 0. The FSM stays in DONE until `rst`; `start` is ignored.
- i==j case: both swap writes hit the same address with the same value. The result is correct and needs no special handling.
- S-array sums are 8-bit with natural wrap. `k` never exceeds MSG_LEN-1.

## Timing
- All three memories have a 1-cycle read latency: an address held in cycle n gives valid q in cycle n+1.
- Each byte takes 8 cycles (FETCH_SI through WRITE_D).
- If `start` is sampled at edge t, `finish` rises in cycle t+8·MSG_LEN+1. For MSG_LEN=32 that is 257 cycles.
- `s_wren` and `d_wren` are never asserted in the same cycle.
- `rst` asserted in any state takes effect at the next edge: state IDLE, all outputs 0, all registers 0. A following `start` restarts from i=0, j=0.
  - S is not restored. Any swaps already written remain in the RAM.

## Configuration
- `RC4_TEXT_CHECK_EN` defined:
  - A `key_ok` output is added. It resets to 0, is set to 1 on leaving IDLE, and stays 1 through DONE on success.
  - In XOR, if `s_q`^`e_q` is neither 8'h61..8'h7A nor 8'h20, the FSM goes straight to DONE with `key_ok`=0. That byte is not written (`d_wren` stays 0).
  - This is used by the brute-force key search to reject keys early.
- Not defined: no `key_ok` port, no check, and every byte is written.

## Test plan
- S preloaded with identity (S[x]=x), ROM all 8'h00, MSG_LEN=2, pulse `start` → bytes 8'h02, 8'h05 written. Afterwards S[2]=3, S[3]=2, and all other S entries are unchanged.
- S preloaded with the KSA result for key 24'h4B6579, ROM = BB F3 16 E8 D9 40 AF 0A D3, MSG_LEN=9, macro off → decrypted RAM holds "Plaintext" (50 6C 61 69 6E 74 65 78 74). `finish` rises exactly 73 cycles after `start` is sampled.
- Same stimulus with `RC4_TEXT_CHECK_EN` → `finish`=1 and `key_ok`=0 after byte 0 (8'h50 fails the check), with `d_wren` never asserted.
- Identity S, ROM = 8'h62 8'h65 for MSG_LEN=2, macro on → decrypted bytes 8'h60^…; choose ROM = 8'h63, 8'h64 so the outputs are 8'h61, 8'h61 → `key_ok`=1, both bytes written.
- `rst` pulsed during SWAP_J of byte 3, then `start` → all outputs are 0 the cycle after `rst`. The run restarts with `e_addr`/`d_addr` from 0 and completes with `finish`.
- `start` held high through DONE → no further memory writes; `finish` stays 1.
